// File: rtl/tug_pkg.sv
// ----------------------------------------------------------------------------
// tug_pkg : shared types for the tug-of-war match controller and playfield
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package tug_pkg;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_L    = 2'b01,
    WIN_R    = 2'b10
  } winner_t;

  typedef enum logic [2:0] {
    RST_PF,
    PLAY,
    SCORE,
    HOLD,
    OVER
  } match_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tug_match_ctrl_key_edge.sv
// ----------------------------------------------------------------------------
// key_edge : rising-edge detector for one synchronized player key
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module key_edge (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic rise
);

  logic hist_q;
  logic hist_d;

  assign hist_d = key;

  // History resets high so a key already held when reset drops is not an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q <= 1'b1;
    end else begin
      hist_q <= hist_d;
    end
  end

  assign rise = key & ~hist_q;

endmodule

`default_nettype wire

// File: rtl/tug_match_ctrl.sv
// ----------------------------------------------------------------------------
// tug_match_ctrl : round/match sequencer, push-pulse generation and scoring
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tug_match_ctrl
  import tug_pkg::*;
#(
  parameter int WIN_SCORE   = 3,
  parameter int RST_CYCLES  = 2,
  parameter int HOLD_CYCLES = 4,
  localparam int SW         = $clog2(WIN_SCORE + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          key_L,
  input  logic          key_R,
  input  logic [1:0]    pf_winner,
  output logic          pf_reset,
  output logic          pf_L,
  output logic          pf_R,
  output logic [SW-1:0] score_L,
  output logic [SW-1:0] score_R,
  output logic [1:0]    match_winner,
  output logic          round_active
);

  localparam int            CW        = $clog2(max_int(RST_CYCLES, HOLD_CYCLES) + 1);
  localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [SW-1:0] SC_MAX    = SW'(WIN_SCORE);

  logic rise_L;
  logic rise_R;
  logic both_rise;

  key_edge u_edge_l (.clk(clk), .reset(reset), .key(key_L), .rise(rise_L));
  key_edge u_edge_r (.clk(clk), .reset(reset), .key(key_R), .rise(rise_R));

  // Both keys high now and not both high last cycle, expressed via the edges.
  assign both_rise = (rise_L & key_R) | (rise_R & key_L);

  match_state_t  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] score_L_q, score_L_d;
  logic [SW-1:0] score_R_q, score_R_d;
  winner_t       last_win_q, last_win_d;
  winner_t       match_winner_q, match_winner_d;
  logic          pf_L_q, pf_L_d;
  logic          pf_R_q, pf_R_d;
  logic [SW-1:0] new_score;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    score_L_d      = score_L_q;
    score_R_d      = score_R_q;
    last_win_d     = last_win_q;
    match_winner_d = match_winner_q;
    new_score      = '0;
    pf_L_d         = rise_L & (state_q == PLAY);
    pf_R_d         = rise_R & (state_q == PLAY);

    case (state_q)
      RST_PF: begin
        if (cnt_q == RST_LAST) begin
          state_d = PLAY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PLAY: begin
        if (pf_winner == WIN_L || pf_winner == WIN_R) begin
          last_win_d = winner_t'(pf_winner);
          state_d    = SCORE;
        end
      end
      SCORE: begin
        new_score = (last_win_q == WIN_L) ? score_L_q : score_R_q;
        if (new_score < SC_MAX) begin
          new_score = new_score + SW'(1);
        end
        if (last_win_q == WIN_L) begin
          score_L_d = new_score;
        end else begin
          score_R_d = new_score;
        end
        if (new_score == SC_MAX) begin
          match_winner_d = last_win_q;
          state_d        = OVER;
        end else begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = RST_PF;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      OVER: begin
        if (both_rise) begin
          score_L_d      = '0;
          score_R_d      = '0;
          match_winner_d = WIN_NONE;
          state_d        = RST_PF;
          cnt_d          = '0;
        end
      end
      default: begin
        state_d = RST_PF;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= RST_PF;
      cnt_q          <= '0;
      score_L_q      <= '0;
      score_R_q      <= '0;
      last_win_q     <= WIN_NONE;
      match_winner_q <= WIN_NONE;
      pf_L_q         <= 1'b0;
      pf_R_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      score_L_q      <= score_L_d;
      score_R_q      <= score_R_d;
      last_win_q     <= last_win_d;
      match_winner_q <= match_winner_d;
      pf_L_q         <= pf_L_d;
      pf_R_q         <= pf_R_d;
    end
  end

  assign pf_reset     = reset | (state_q == RST_PF);
  assign pf_L         = pf_L_q;
  assign pf_R         = pf_R_q;
  assign score_L      = score_L_q;
  assign score_R      = score_R_q;
  assign match_winner = match_winner_q;
  assign round_active = (state_q == PLAY);

endmodule

`default_nettype wire
